// File: rtl/ack_sequencer_param_if.sv
// Bus bundle for the INTA acknowledge sequencer: INTA strobe, mode and
// cascade qualifiers, ICW bytes, priority winner, and the ISR/data-bus outputs.
interface ack_sequencer_param_if #(
  parameter int IRQ_NUM = 8
);
  logic               inta_n;
  logic               mode_8086;
  logic               interval_4;
  logic               cascade_slave;
  logic               cascade_match;
  logic [7:0]         vector_icw1;
  logic [7:0]         vector_icw2;
  logic [IRQ_NUM-1:0] pending_irq;
  logic [IRQ_NUM-1:0] isr_set;
  logic               spurious;
  logic               end_of_ack;
  logic               ack_busy;
  logic [7:0]         data_out;
  logic               data_out_en;

  // Control block / bus side that drives INTA and observes the sequencer.
  modport master (
    output inta_n, mode_8086, interval_4, cascade_slave, cascade_match,
    output vector_icw1, vector_icw2, pending_irq,
    input  isr_set, spurious, end_of_ack, ack_busy, data_out, data_out_en
  );

  // Sequencer side.
  modport slave (
    input  inta_n, mode_8086, interval_4, cascade_slave, cascade_match,
    input  vector_icw1, vector_icw2, pending_irq,
    output isr_set, spurious, end_of_ack, ack_busy, data_out, data_out_en
  );
endinterface

// File: rtl/ack_sequencer_param.sv
// INTA acknowledge sequencer: follows the 8086 (two pulse) or MCS-80
// (three pulse) INTA train, latches the winning IR at ACK1, pulses the ISR
// set and end-of-acknowledge strobes, and drives CALL/vector bytes.
module ack_sequencer_param #(
  parameter int IRQ_NUM = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  ack_sequencer_param_if.slave bus
);
  localparam int          ID_W = $clog2(IRQ_NUM);
  localparam int unsigned N    = IRQ_NUM;

  typedef enum logic [1:0] {IDLE, P1, P2, P3} state_t;

  state_t          state;
  logic            inta_q;
  logic            fall;
  logic            rise;
  // cascade_slave is consumed only on the IDLE->P1 edge, so it is not kept.
  logic            mode_q;
  logic            int4_q;
  logic            match_q;
  logic [ID_W-1:0] id_q;
  logic [ID_W-1:0] id_enc;
  logic [N-1:0]    lowest;
  logic [7:0]      id_mask;
  logic [7:0]      low_i4;
  logic [7:0]      low_i8;
  logic [7:0]      vec_8086;

  assign fall = inta_q & ~bus.inta_n;
  assign rise = ~inta_q & bus.inta_n;

  // Encode the winner; scanning downward lets the lowest set bit win.
  always_comb begin
    id_enc = ID_W'(N - 1);
    lowest = '0;
    for (int unsigned i = N; i > 0; i--) begin
      if (bus.pending_irq[i-1]) begin
        id_enc      = ID_W'(i - 1);
        lowest      = '0;
        lowest[i-1] = 1'b1;
      end
    end
  end

  // Vector and CALL address bytes built from the latched IR index.
  always_comb begin
    id_mask  = 8'(N - 1);
    vec_8086 = (bus.vector_icw2 & ~id_mask) | 8'(id_q);
    low_i4   = (bus.vector_icw1 & ~((id_mask << 2) | 8'h03)) | (8'(id_q) << 2);
    low_i8   = (bus.vector_icw1 & ~((id_mask << 3) | 8'h07)) | (8'(id_q) << 3);
  end

  // Pulse-train FSM with registered strobes and bus drive.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state           <= IDLE;
      inta_q          <= 1'b1;
      mode_q          <= 1'b0;
      int4_q          <= 1'b0;
      match_q         <= 1'b0;
      id_q            <= '0;
      bus.isr_set     <= '0;
      bus.spurious    <= 1'b0;
      bus.end_of_ack  <= 1'b0;
      bus.ack_busy    <= 1'b0;
      bus.data_out    <= '0;
      bus.data_out_en <= 1'b0;
    end else begin
      inta_q         <= bus.inta_n;
      bus.isr_set    <= '0;
      bus.end_of_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (fall) begin
            state        <= P1;
            mode_q       <= bus.mode_8086;
            int4_q       <= bus.interval_4;
            match_q      <= bus.cascade_match;
            id_q         <= id_enc;
            bus.isr_set  <= lowest;
            bus.spurious <= (bus.pending_irq == '0);
            bus.ack_busy <= 1'b1;
            if (!bus.mode_8086 && !bus.cascade_slave) begin
              bus.data_out    <= 8'hCD;
              bus.data_out_en <= 1'b1;
            end
          end
        end
        P1: begin
          if (rise) begin
            bus.data_out    <= '0;
            bus.data_out_en <= 1'b0;
          end else if (fall) begin
            state <= P2;
            if (match_q) begin
              bus.data_out    <= mode_q ? vec_8086 : (int4_q ? low_i4 : low_i8);
              bus.data_out_en <= 1'b1;
            end
          end
        end
        P2: begin
          if (rise) begin
            bus.data_out    <= '0;
            bus.data_out_en <= 1'b0;
            if (mode_q) begin
              state          <= IDLE;
              bus.end_of_ack <= 1'b1;
              bus.ack_busy   <= 1'b0;
              bus.spurious   <= 1'b0;
            end
          end else if (fall && !mode_q) begin
            state <= P3;
            if (match_q) begin
              bus.data_out    <= bus.vector_icw2;
              bus.data_out_en <= 1'b1;
            end
          end
        end
        P3: begin
          if (rise) begin
            state           <= IDLE;
            bus.end_of_ack  <= 1'b1;
            bus.ack_busy    <= 1'b0;
            bus.spurious    <= 1'b0;
            bus.data_out    <= '0;
            bus.data_out_en <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/ack_sequencer_param.md
Name: ack_sequencer_param

Overview:
- Parametrised successor to the INTA acknowledge logic in the 8259A control block.
- Clocked FSM. Tracks the INTA pulse train and latches the winning IR at ACK1.
- Generates one-cycle ISR-set and end-of-acknowledge strobes.
- Drives CALL opcode / vector bytes on the data bus in 8086 and MCS-80 modes; supports IRQ_NUM of 2, 4 or 8 inputs.
- Sits between the priority resolver / ISR and the data-bus buffer.

Parameters:
- IRQ_NUM, 8, number of IR inputs; power of two, 2..8.
- ID_W, $clog2(IRQ_NUM), width of the IR index (derived; not overridden).

Ports:
- clock  input  1  system clock
- reset_n  input  1  synchronous active-low reset
- inta_n  input  1  INTA strobe, already synchronised to clock
- mode_8086  input  1  1 = 8086 (two pulses), 0 = MCS-80 (three pulses)
- interval_4  input  1  MCS-80 call interval: 1 = 4, 0 = 8
- cascade_slave  input  1  1 = this device is a cascaded slave
- cascade_match  input  1  1 = this device supplies the vector/address bytes of this sequence
- vector_icw1  input  8  ICW1[7:0], MCS-80 low address base
- vector_icw2  input  8  ICW2, 8086 vector base / MCS-80 high address
- pending_irq  input  IRQ_NUM  one-hot winner from the priority resolver
- isr_set  output  IRQ_NUM  one-cycle pulse at ACK1 selecting the ISR bit to set
- spurious  output  1  sticky for the sequence: no IR was pending at ACK1
- end_of_ack  output  1  one-cycle pulse after the final INTA rising edge (AEOI hook)
- ack_busy  output  1  high from ACK1 detection until return to IDLE
- data_out  output  8  byte to drive on the bus
- data_out_en  output  1  bus drive enable

Behaviour:
- Reset (reset_n=0 at a clock edge): FSM=IDLE; all outputs 0; inta_q=1. Applies mid-sequence too: the sequence is aborted and no end_of_ack is generated.
- Edges: inta_q is inta_n registered. fall = inta_q & ~inta_n; rise = ~inta_q & inta_n.
- States and transitions: IDLE -> P1 on fall; P1 -> P2 on fall; P2 -> P3 on fall (MCS-80 only).
- Last pulse is P2 (8086) or P3 (MCS-80). On rise during the last pulse: end_of_ack pulses on the next cycle, ack_busy=0, FSM -> IDLE.
- Latched at the IDLE->P1 transition and held for the whole sequence; later input changes are ignored:
  - mode_8086, interval_4, cascade_slave, cascade_match
  - id = encoded pending_irq
- Spurious case: pending_irq==0 -> id = IRQ_NUM-1, spurious=1, isr_set stays 0. Otherwise isr_set = pending_irq for exactly one cycle (the cycle after fall). pending_irq with more than one bit set is illegal; lowest set bit wins.
- Vector/address bytes:
  - 8086 vector = {icw2[7:ID_W], id}.
  - MCS-80 low byte, interval 4: icw1 with bits [ID_W+1:2] replaced by id and bits [1:0] = 0.
  - MCS-80 low byte, interval 8: icw1 with bits [ID_W+2:3] replaced by id and bits [2:0] = 0.
  - MCS-80 high byte = icw2.
- Byte per pulse:
  - MCS-80: P1 drives 0xCD only if cascade_slave=0. P2 drives the low byte and P3 the high byte, only if cascade_match=1.
  - 8086: P1 drives nothing. P2 drives the vector if cascade_match=1.
- Drive timing: data_out/data_out_en are registered. Asserted the cycle after the fall that enters a driving pulse; cleared the cycle after the matching rise. When data_out_en=0, data_out=0x00.
- Boundaries:
  - A fall while already in the last pulse is impossible (a rise must come first).
  - Rise in IDLE is ignored.
  - inta_n held low indefinitely: state and drive are held.

Test Plan:
- IRQ_NUM=8, 8086, icw2=0x48, pending=0x04, cascade_match=1, two INTA pulses -> isr_set=0x04 for 1 cycle after the first fall; no drive on P1; data_out=0x4A during P2; end_of_ack 1 cycle after the second rise.
- MCS-80, interval_4=1, icw1=0xE0, icw2=0x12, pending=0x04, master, match=1, three pulses -> bytes 0xCD, 0xE8, 0x12 in order; end_of_ack after the third rise.
- MCS-80, interval_4=0, icw1=0xC0, pending=0x20 -> P2 low byte 0xE8. Then cascade_slave=1 -> P1 not driven, P2/P3 driven. Then cascade_slave=0, match=0 -> only 0xCD driven.
- Spurious: 8086, pending=0x00, icw2=0x48 -> isr_set never asserted, spurious=1, P2 data 0x4F.
- IRQ_NUM=4, icw2=0x48, pending=0x8 -> 8086 vector 0x4B; MCS-80 interval 4 with icw1=0xE0 -> low byte 0xEC.
- reset_n=0 during P2 of an 8086 sequence -> next cycle FSM=IDLE, data_out_en=0, ack_busy=0, no end_of_ack. A following full sequence completes normally.
